// File: rtl/user_reset_seq.sv
// Staggered multi-domain reset sequencer: global hold, then one active-low
// domain release per stagger slot, with per-domain masking, re-release and soft reset.
module user_reset_seq #(
  parameter int CHANNELS       = 4,
  parameter int HOLD_CYCLES    = 4095,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                soft_rst_i,
  input  logic [CHANNELS-1:0] chan_mask_i,
  output logic [CHANNELS-1:0] rst_n_o,
  output logic                done_o,
  output logic [1:0]          state_o,
  output logic [7:0]          soft_cnt_o
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_STAGGER = 2'b01,
    ST_RUN     = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [STG_W-1:0]    r_stg_cnt;
  logic [IDX_W-1:0]    r_chan_idx;
  logic                r_done;
  logic                r_soft_prev;
  logic [7:0]          r_soft_cnt;
  logic                w_any_rst;
  logic                w_hold_hit;
  logic                w_stg_hit;
  logic [CHANNELS-1:0] w_slot;

  assign w_any_rst  = wb_rst_i | soft_rst_i;
  assign w_hold_hit = (r_state == ST_HOLD) && (r_hold_cnt == HOLD_LAST);
  assign w_stg_hit  = (r_state == ST_STAGGER) && (r_stg_cnt == STG_LAST);

  always_comb begin
    w_state_next = r_state;
    if (w_any_rst) begin
      w_state_next = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_hold_hit) begin
            w_state_next = (CHANNELS == 1) ? ST_RUN : ST_STAGGER;
          end
        end
        ST_STAGGER: begin
          if (w_stg_hit && (r_chan_idx == IDX_LAST)) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN:  w_state_next = ST_RUN;
        default: w_state_next = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_any_rst) begin
      r_state <= ST_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_RUN);
    end
  end

  // Hold counter, then slot spacing counter and index of the next channel to slot.
  always_ff @(posedge wb_clk_i) begin
    if (w_any_rst) begin
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
      r_chan_idx <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (!w_hold_hit) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end else begin
            r_stg_cnt  <= '0;
            r_chan_idx <= IDX_W'(1);
          end
        end
        ST_STAGGER: begin
          if (w_stg_hit) begin
            r_stg_cnt <= '0;
            if (r_chan_idx != IDX_LAST) begin
              r_chan_idx <= r_chan_idx + 1'b1;
            end
          end else begin
            r_stg_cnt <= r_stg_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Soft-reset edge counter survives soft reset; only the hard reset clears it.
  always_ff @(posedge wb_clk_i) begin
    r_soft_prev <= soft_rst_i;
    if (wb_rst_i) begin
      r_soft_cnt <= '0;
    end else if (soft_rst_i && !r_soft_prev && (r_soft_cnt != 8'hFF)) begin
      r_soft_cnt <= r_soft_cnt + 8'd1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic             r_armed;
    logic             r_rel;
    logic [STG_W-1:0] r_pend_cnt;

    if (gi == 0) begin : g_first
      assign w_slot[gi] = w_hold_hit;
    end else begin : g_rest
      assign w_slot[gi] = w_stg_hit && (r_chan_idx == IDX_W'(gi));
    end

    // r_armed: slot has passed, so the mask now decides release vs pending.
    always_ff @(posedge wb_clk_i) begin
      if (w_any_rst) begin
        r_armed    <= 1'b0;
        r_rel      <= 1'b0;
        r_pend_cnt <= '0;
      end else if (w_slot[gi]) begin
        r_armed    <= 1'b1;
        r_rel      <= chan_mask_i[gi];
        r_pend_cnt <= '0;
      end else if (r_armed) begin
        if (!chan_mask_i[gi]) begin
          r_rel      <= 1'b0;
          r_pend_cnt <= '0;
        end else if (!r_rel) begin
          if (r_pend_cnt == STG_LAST) begin
            r_rel      <= 1'b1;
            r_pend_cnt <= '0;
          end else begin
            r_pend_cnt <= r_pend_cnt + 1'b1;
          end
        end
      end
    end

    assign rst_n_o[gi] = r_rel;
  end

  assign done_o     = r_done;
  assign state_o    = r_state;
  assign soft_cnt_o = r_soft_cnt;

endmodule

// File: tb/tb_user_reset_seq.sv
// Self-checking bench for user_reset_seq: directed test-plan phases plus random
// mask/reset traffic, all compared against a timestamp-based reference model.
module tb_user_reset_seq;
  localparam int CH   = 4;
  localparam int HOLD = 8;
  localparam int STG  = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          soft_rst_i;
  logic [CH-1:0] chan_mask_i;
  logic [CH-1:0] rst_n_o;
  logic          done_o;
  logic [1:0]    state_o;
  logic [7:0]    soft_cnt_o;

  user_reset_seq #(
    .CHANNELS      (CH),
    .HOLD_CYCLES   (HOLD),
    .STAGGER_CYCLES(STG)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .soft_rst_i (soft_rst_i),
    .chan_mask_i(chan_mask_i),
    .rst_n_o    (rst_n_o),
    .done_o     (done_o),
    .state_o    (state_o),
    .soft_cnt_o (soft_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: absolute edge numbers. A channel is released once its slot
  // has passed and the mask has been 1 on every edge since max(slot, now-STG+1).
  int            edge_n = 0;
  int            e0 = -1;
  int            last_zero [CH];
  int            m_soft_cnt = 0;
  bit            m_soft_prev = 1'b0;
  logic [CH-1:0] m_rst_n = '0;
  logic [1:0]    m_state = 2'b00;
  logic          m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_step();
    int k;
    int slot;
    int lim;
    edge_n++;
    if (wb_rst_i) begin
      m_soft_cnt = 0;
      e0 = -1;
    end else if (soft_rst_i) begin
      if (!m_soft_prev && m_soft_cnt < 255) m_soft_cnt++;
      e0 = -1;
    end else if (e0 < 0) begin
      e0 = edge_n;
    end
    m_soft_prev = soft_rst_i;
    for (int i = 0; i < CH; i++) begin
      if (!chan_mask_i[i]) last_zero[i] = edge_n;
    end
    m_rst_n = '0;
    m_state = 2'b00;
    if (e0 >= 0) begin
      k = edge_n - e0;
      for (int i = 0; i < CH; i++) begin
        slot = e0 + HOLD + i * STG;
        lim  = (edge_n - STG + 1 > slot) ? edge_n - STG + 1 : slot;
        m_rst_n[i] = (edge_n >= slot) && (last_zero[i] < lim);
      end
      if (k < HOLD) m_state = 2'b00;
      else if (k < HOLD + (CH - 1) * STG) m_state = 2'b01;
      else m_state = 2'b10;
    end
    m_done = (m_state == 2'b10);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    model_step();
    #1;
    chk("rst_n", rst_n_o, m_rst_n);
    chk("done", done_o, m_done);
    chk("state", state_o, m_state);
    chk("soft_cnt", soft_cnt_o, m_soft_cnt);
  endtask

  task automatic report(input string name);
    $display("[%0t] %s: rst_n=%b done=%b state=%b soft_cnt=%0d", $time, name,
             rst_n_o, done_o, state_o, soft_cnt_o);
  endtask

  task automatic soft_pulse();
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    tick();
  endtask

  int idx;

  initial begin
    for (int i = 0; i < CH; i++) last_zero[i] = -1000;
    wb_rst_i    = 1'b1;
    soft_rst_i  = 1'b0;
    chan_mask_i = '1;

    // Power-up
    repeat (3) tick();
    chk("reset_rst_n", rst_n_o, 4'b0000);
    chk("reset_state", state_o, 2'b00);
    wb_rst_i = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      tick();
      case (k)
        7:  chk("pu_e7", rst_n_o, 4'b0000);
        8:  chk("pu_e8", rst_n_o, 4'b0001);
        12: chk("pu_e12", rst_n_o, 4'b0011);
        16: chk("pu_e16", rst_n_o, 4'b0111);
        19: chk("pu_e19_done", done_o, 1'b0);
        20: begin
          chk("pu_e20", rst_n_o, 4'b1111);
          chk("pu_e20_done", done_o, 1'b1);
          chk("pu_e20_state", state_o, 2'b10);
        end
        default: ;
      endcase
    end
    report("power_up");

    // Mask at slot, then late release
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i    = 1'b0;
    chan_mask_i = 4'b1101;
    repeat (21) tick();
    chk("mask_slot_rst_n", rst_n_o, 4'b1101);
    chk("mask_slot_done", done_o, 1'b1);
    chan_mask_i = 4'b1111;
    repeat (3) tick();
    chk("mask_em2", rst_n_o, 4'b1101);
    tick();
    chk("mask_em3", rst_n_o, 4'b1111);
    report("mask_at_slot");

    // Mask drop in RUN
    chan_mask_i = 4'b1011;
    tick();
    chk("drop_edge", rst_n_o, 4'b1011);
    chan_mask_i = 4'b1111;
    repeat (3) tick();
    chk("drop_em2", rst_n_o, 4'b1011);
    tick();
    chk("drop_em3", rst_n_o, 4'b1111);
    report("mask_drop_run");

    // Soft reset pulses in RUN
    for (int p = 0; p < 3; p++) begin
      soft_rst_i = 1'b1;
      tick();
      chk("soft_rst_n", rst_n_o, 4'b0000);
      chk("soft_state", state_o, 2'b00);
      tick();
      soft_rst_i = 1'b0;
      repeat (21) tick();
      chk("soft_reseq", rst_n_o, 4'b1111);
    end
    chk("soft_cnt3", soft_cnt_o, 8'd3);
    report("soft_reset_x3");
    for (int p = 0; p < 297; p++) soft_pulse();
    chk("soft_sat", soft_cnt_o, 8'd255);
    report("soft_saturate");

    // Reset mid-stagger (last soft_pulse tick was E0)
    repeat (12) tick();
    chk("mid_e12", rst_n_o, 4'b0011);
    soft_rst_i = 1'b1;
    tick();
    chk("mid_e13", rst_n_o, 4'b0000);
    soft_rst_i = 1'b0;
    repeat (8) tick();
    chk("mid_new_e7", rst_n_o, 4'b0000);
    tick();
    chk("mid_new_e8", rst_n_o, 4'b0001);
    report("mid_stagger");

    // Priority of wb_rst_i over soft_rst_i
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    repeat (5) soft_pulse();
    chk("prio_cnt5", soft_cnt_o, 8'd5);
    wb_rst_i   = 1'b1;
    soft_rst_i = 1'b1;
    tick();
    chk("prio_cnt0", soft_cnt_o, 8'd0);
    chk("prio_rst_n", rst_n_o, 4'b0000);
    wb_rst_i   = 1'b0;
    soft_rst_i = 1'b0;
    report("priority");

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      wb_rst_i   = ($urandom_range(0, 149) == 0);
      soft_rst_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, CH - 1);
        chan_mask_i[idx] = ~chan_mask_i[idx];
      end
      tick();
      if (t % 100 == 99) report("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/user_reset_seq.md
# user_reset_seq

Parametrised reset sequencer for the user project area. It replaces the single fixed 4095-cycle reset stretcher with one sequencer that drives CHANNELS independent active-low reset domains, for example a core plus its peripherals or buses. After the global hold expires, it releases the domains one at a time on staggered slots. It also supports per-domain masking and re-release, a software (LA-driven) soft reset, and debug status for the logic analyzer.

## Interface
- CHANNELS, 4: number of reset domains; range 1..16.
- HOLD_CYCLES, 4095: global hold length in clock edges; must be >= 1.
- STAGGER_CYCLES, 16: spacing between domain releases, and the per-domain re-release hold; must be >= 1.
- HOLD_W / STG_W: localparams sized to $clog2 of HOLD_CYCLES+1 and STAGGER_CYCLES+1.
- wb_clk_i  in  1  the single clock; all state is on its rising edge.
- wb_rst_i  in  1  reset, synchronous and active-high; has priority over every other input.
- soft_rst_i  in  1  synchronous soft reset, level-sensitive and active-high (typically driven from an LA probe).
- chan_mask_i  in  CHANNELS  per-domain enable; 1 = domain may be released.
- rst_n_o  out  CHANNELS  registered active-low domain resets.
- done_o  out  1  high once the stagger sequence is complete (state RUN).
- state_o  out  2  current state: 00 HOLD, 01 STAGGER, 10 RUN.
- soft_cnt_o  out  8  saturating count of soft_rst_i rising edges.

## Operation
- All outputs are registered.
- Reset values, forced by wb_rst_i = 1:
  - rst_n_o = 0, done_o = 0, state_o = 00 (HOLD), soft_cnt_o = 0.
  - All counters and per-domain flags are cleared.
- Soft reset: soft_rst_i = 1 in any state has the same effect as wb_rst_i, except that soft_cnt_o is preserved.
- soft_cnt_o increments when soft_rst_i is sampled 1 and was sampled 0 on the previous edge. It saturates at 255 and is cleared only by wb_rst_i.
- HOLD:
  - hold_cnt increments on each edge where both reset inputs are sampled 0.
  - When hold_cnt reaches HOLD_CYCLES, the slot for channel 0 occurs and the state moves to STAGGER.
- STAGGER:
  - Channel i's slot occurs STAGGER_CYCLES edges after channel i-1's slot.
  - At its slot, channel i is released only if chan_mask_i[i] = 1 on that edge. Otherwise it stays low and is marked pending.
  - The state moves to RUN on the edge of channel CHANNELS-1's slot; done_o rises on that same edge.
  - With CHANNELS = 1, the state goes from HOLD directly to RUN.
- Pending domain:
  - A pending domain's slot has passed but it has not been released. Pending status applies in both STAGGER and RUN.
  - While its mask bit is 1, its per-domain counter counts edges; the domain is released when the count reaches STAGGER_CYCLES.
  - Any edge sampling the mask bit as 0 clears that counter.
- Mask drop:
  - If a released domain's mask bit is sampled 0, its rst_n_o goes 0 on that edge and it becomes pending.
  - Reasserting the mask bit re-releases it after a full STAGGER_CYCLES hold. There is never an immediate re-release.
- Simultaneous events:
  - wb_rst_i takes priority over soft_rst_i, which takes priority over slot or mask events.
  - A mask drop on the same edge as the domain's slot means the domain is not released.
- Reset mid-sequence (in HOLD or STAGGER) restarts the full sequence from HOLD. Already-released domains go low again.

## Timing
- E0: the first edge at which both wb_rst_i and soft_rst_i are sampled 0.
- Unmasked channel i: rst_n_o[i] rises on edge E0 + HOLD_CYCLES + i*STAGGER_CYCLES, i.e. it is visible just after that edge.
- done_o and state_o = 10 become valid on edge E0 + HOLD_CYCLES + (CHANNELS-1)*STAGGER_CYCLES.
- Re-release: Em is the first edge sampling the mask bit as 1 while the domain is pending and its slot has passed. rst_n_o rises on edge Em + STAGGER_CYCLES - 1, giving STAGGER_CYCLES sampled edges in total.
- Reset or mask-drop assertion: rst_n_o = 0 on the same edge that samples the request, so 1 cycle of latency. The reset is held for as long as the request is high.
- Counters never wrap: hold_cnt stops at HOLD_CYCLES, per-domain counters stop at STAGGER_CYCLES, soft_cnt_o stops at 255.

## Test plan
All benches use CHANNELS = 4, HOLD_CYCLES = 8, STAGGER_CYCLES = 4.
- Power-up: wb_rst_i high for 3 edges, then low (E0). Expect rst_n_o to go 0001 at E0+8, 0011 at E0+12, 0111 at E0+16, 1111 at E0+20. done_o rises at E0+20, with state_o = 10.
- Mask at slot: chan_mask_i = 1101 through the sequence. Expect bit 1 to stay 0 with done_o = 1 at E0+20. Then set mask = 1111 at edge Em; expect bit 1 to rise at Em+3.
- Mask drop in RUN: clear mask bit 2 for 1 edge. Expect rst_n_o[2] = 0 on that edge. After the mask returns to 1, expect release 4 edges later, with no other bits disturbed.
- Soft reset: pulse soft_rst_i for 2 edges in RUN, 3 times. Expect rst_n_o = 0000, state_o = 00, and done_o = 0 each time, soft_cnt_o = 3, and a full re-sequence from each new E0. Hold soft_rst_i high for 300 rising edges in total; expect soft_cnt_o = 255.
- Reset mid-stagger: assert soft_rst_i at E0+13, when rst_n_o = 0011. Expect 0000 on that edge. After release, the new E0 gives channel 0 at new E0+8.
- Priority: assert wb_rst_i and soft_rst_i on the same edge with soft_cnt_o = 5. Expect soft_cnt_o = 0 and rst_n_o = 0000.
